// File: rtl/tohost_pkg.sv
// Shared types and the tohost write decision rule for the end-of-test monitor.
package tohost_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        V_IGNORE,
        V_PASS,
        V_FAIL,
        V_ERROR
    } verdict_t;

    // riscv-tests writes 1 to tohost on success; odd values carry (testnum << 1) | 1.
    localparam int unsigned PASS_CODE  = 1;
    // Widest data bus the decision function accepts; narrower buses are zero-extended.
    localparam int unsigned MAX_DATA_W = 256;

    // Decide what a tohost write means. Partial strobes are always illegal,
    // a zero word is a no-op, 1 is PASS, other odd values are FAIL, even nonzero is illegal.
    function automatic verdict_t classify(input logic [MAX_DATA_W-1:0] wdata,
                                          input logic                  full_strobe);
        if (!full_strobe) begin
            return V_ERROR;
        end
        if (wdata == '0) begin
            return V_IGNORE;
        end
        if (wdata == MAX_DATA_W'(PASS_CODE)) begin
            return V_PASS;
        end
        if (wdata[0]) begin
            return V_FAIL;
        end
        return V_ERROR;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear has priority over counting; the counter holds once saturated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// Snoops dmem writes for riscv-tests tohost and reports a sticky PASS/FAIL/TIMEOUT/ERROR result.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter int unsigned        ADDR_W         = 32,
    parameter int unsigned        DATA_W         = 32,
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR    = 'h1000,
    parameter int unsigned        TIMEOUT_CYCLES = 20000,
    parameter int unsigned        CNT_W          = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  clear,
    input  logic [DATA_W/8-1:0]   mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic                  proto_err,
    output logic [DATA_W-2:0]     fail_testnum,
    output logic [CNT_W-1:0]      cycle_count
);

    // The watchdog has its own counter so a narrow cycle_count cannot mask expiry.
    localparam int unsigned     WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    verdict_t          verdict;
    logic              hit;
    logic              decisive;
    logic              run_en;
    logic              cnt_clr;
    logic              wd_expired;
    logic [WD_W-1:0]   wd_count;
    logic [DATA_W-2:0] testnum_q;

    assign hit        = (|mem_we) && (mem_addr == TOHOST_ADDR);
    assign verdict    = classify(MAX_DATA_W'(mem_wdata), &mem_we);
    assign decisive   = hit && (verdict != V_IGNORE);
    assign run_en     = (state == ST_RUN);
    assign cnt_clr    = clear || ((state == ST_IDLE) && start);
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_count == WD_LAST);

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .en    (run_en),
        .clr   (cnt_clr),
        .count (cycle_count)
    );

    sat_counter #(.W(WD_W)) u_watchdog (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .en    (run_en),
        .clr   (cnt_clr),
        .count (wd_count)
    );

    // Next-state: decisive hit beats watchdog, clear beats everything, results are sticky.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (decisive) begin
                    case (verdict)
                        V_PASS:  state_next = ST_PASS;
                        V_FAIL:  state_next = ST_FAIL;
                        default: state_next = ST_ERROR;
                    endcase
                end else if (wd_expired) begin
                    state_next = ST_TIMEOUT;
                end
            end
            default: begin
            end
        endcase
        if (clear) begin
            state_next = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the failing test number on entry to FAIL; zero otherwise.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            testnum_q <= '0;
        end else if (clear) begin
            testnum_q <= '0;
        end else if ((state == ST_RUN) && (state_next == ST_FAIL)) begin
            testnum_q <= mem_wdata[DATA_W-1:1];
        end
    end

    assign pass         = (state == ST_PASS);
    assign fail         = (state == ST_FAIL);
    assign timeout      = (state == ST_TIMEOUT);
    assign proto_err    = (state == ST_ERROR);
    assign done         = pass | fail | timeout | proto_err;
    assign fail_testnum = testnum_q;

endmodule

// File: tb/tb_tohost_monitor.sv
// Scoreboard bench for tohost_monitor: two instances (watchdog 50 / wide count, watchdog off / 4-bit count).
module tb_tohost_monitor;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic        clear;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic        a_done, a_pass, a_fail, a_timeout, a_proto;
    logic [30:0] a_tn;
    logic [31:0] a_cnt;
    logic        b_done, b_pass, b_fail, b_timeout, b_proto;
    logic [30:0] b_tn;
    logic [3:0]  b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sys_clk = ~sys_clk;

    tohost_monitor #(.TIMEOUT_CYCLES(50)) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .clear(clear),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
        .proto_err(a_proto), .fail_testnum(a_tn), .cycle_count(a_cnt)
    );

    tohost_monitor #(.TIMEOUT_CYCLES(0), .CNT_W(4)) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .clear(clear),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
        .proto_err(b_proto), .fail_testnum(b_tn), .cycle_count(b_cnt)
    );

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: a run is "running" with a length in edges; result 0 none,1 pass,2 fail,3 timeout,4 error.
    typedef struct {
        bit          running;
        int          result;
        int unsigned runlen;
        logic [30:0] tn;
    } mdl_t;

    mdl_t        m[2];
    int unsigned m_to[2]   = '{50, 0};
    int unsigned m_cmax[2] = '{32'hFFFF_FFFF, 15};

    function automatic void model_clear(int k);
        m[k].running = 1'b0;
        m[k].result  = 0;
        m[k].runlen  = 0;
        m[k].tn      = '0;
    endfunction

    function automatic void model_edge(int k, logic r, logic st, logic cl,
                                       logic [3:0] we, logic [31:0] ad, logic [31:0] wd);
        int res;
        res = 0;
        if (r || cl) begin
            model_clear(k);
            return;
        end
        if (m[k].running) begin
            if (we != 4'h0 && ad == 32'h1000) begin
                if (we != 4'hF)          res = 4;
                else if (wd == 0)        res = 0;
                else if (wd == 1)        res = 1;
                else if (wd % 2 == 1) begin
                    res = 2;
                    m[k].tn = wd[31:1];
                end else                 res = 4;
            end
            if (res == 0 && m_to[k] != 0 && m[k].runlen == m_to[k] - 1) res = 3;
            m[k].runlen++;
            if (res != 0) begin
                m[k].running = 1'b0;
                m[k].result  = res;
            end
        end else if (m[k].result == 0 && st) begin
            m[k].running = 1'b1;
            m[k].runlen  = 0;
        end
    endfunction

    function automatic logic [35:0] mflags(int k);
        int r;
        r = m[k].result;
        return {r != 0, r == 1, r == 2, r == 3, r == 4, (r == 2) ? m[k].tn : 31'd0};
    endfunction

    function automatic logic [31:0] mcnt(int k);
        return (m[k].runlen > m_cmax[k]) ? m_cmax[k] : m[k].runlen;
    endfunction

    typedef struct packed {
        logic [35:0] fa;
        logic [31:0] ca;
        logic [35:0] fb;
        logic [31:0] cb;
    } exp_t;

    exp_t sbq[$];

    // Apply inputs at a negedge, push the expected post-edge outputs, advance one cycle.
    task automatic step(input logic r, input logic st, input logic cl,
                        input logic [3:0] we, input logic [31:0] ad, input logic [31:0] wd);
        exp_t e;
        sys_rst = r; start = st; clear = cl;
        mem_we = we; mem_addr = ad; mem_wdata = wd;
        for (int k = 0; k < 2; k++) model_edge(k, r, st, cl, we, ad, wd);
        e.fa = mflags(0); e.ca = mcnt(0);
        e.fb = mflags(1); e.cb = mcnt(1);
        sbq.push_back(e);
        @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] we, input logic [31:0] ad, input logic [31:0] wd);
        step(1'b0, 1'b0, 1'b0, we, ad, wd);
    endtask

    task automatic do_start();
        step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int i;
        i = 0;
        while (!a_done && i < budget) begin
            idle(1);
            i++;
        end
        check(nm, a_done, 1);
    endtask

    // Monitor: after every active edge compare both instances with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #2;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("sb_a_flags", {a_done, a_pass, a_fail, a_timeout, a_proto, a_tn}, e.fa);
                check("sb_a_count", a_cnt, e.ca);
                check("sb_b_flags", {b_done, b_pass, b_fail, b_timeout, b_proto, b_tn}, e.fb);
                check("sb_b_count", {28'd0, b_cnt}, e.cb);
            end
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL global_timeout: got no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench time limit");
    end

    initial begin
        logic        r, st, cl;
        logic [3:0]  we;
        logic [31:0] ad, wd;

        sys_rst = 1'b1; start = 1'b0; clear = 1'b0;
        mem_we = '0; mem_addr = '0; mem_wdata = '0;
        for (int k = 0; k < 2; k++) model_clear(k);
        @(negedge sys_clk);
        repeat (3) step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("reset_flags", {a_done, a_pass, a_fail, a_timeout, a_proto, a_tn}, 0);
        check("reset_count", a_cnt, 0);

        // T1: pass after 40 idle cycles, held for 100 cycles of non-decisive traffic.
        idle(2);
        do_start();
        idle(40);
        wr(4'hF, 32'h1000, 32'h1);
        check("t1_pass", a_pass, 1);
        check("t1_count", a_cnt, 41);
        for (int i = 0; i < 100; i++) wr(4'hF, 32'h1000, $urandom);
        check("t1_hold_pass", {a_done, a_pass, a_fail, a_timeout, a_proto}, 5'b11000);
        check("t1_hold_count", a_cnt, 41);

        // T2: odd non-one value -> fail with test number.
        do_clear();
        do_start();
        idle(3);
        wr(4'hF, 32'h1000, 32'h0000_0007);
        wait_done(5, "t2_done");
        check("t2_fail", {a_pass, a_fail}, 2'b01);
        check("t2_testnum", a_tn, 3);

        // T3: watchdog fires exactly 50 edges after start; later pass write ignored.
        do_clear();
        do_start();
        idle(49);
        check("t3_not_yet", a_timeout, 0);
        idle(1);
        check("t3_timeout", a_timeout, 1);
        check("t3_count", a_cnt, 50);
        wr(4'hF, 32'h1000, 32'h1);
        check("t3_sticky", {a_pass, a_timeout}, 2'b01);

        // T4: partial strobe, neighbour address, zero write, even nonzero.
        do_clear();
        do_start();
        wr(4'b0011, 32'h1000, 32'h1);
        check("t4_partial", {a_done, a_proto}, 2'b11);
        do_clear();
        do_start();
        wr(4'hF, 32'h1004, 32'h1);
        check("t4_neighbour", a_done, 0);
        wr(4'hF, 32'h1000, 32'h0);
        check("t4_zero", a_done, 0);
        check("t4_zero_count", a_cnt, 2);
        wr(4'hF, 32'h1000, 32'h10);
        check("t4_even", {a_done, a_proto}, 2'b11);

        // T5: pass coincident with expiry; clear beats write; start+clear stays idle.
        do_clear();
        do_start();
        idle(49);
        wr(4'hF, 32'h1000, 32'h1);
        check("t5_race", {a_pass, a_timeout}, 2'b10);
        step(1'b0, 1'b0, 1'b1, 4'hF, 32'h1000, 32'h1);
        check("t5_clear_write", {a_done, a_pass, a_fail, a_timeout, a_proto}, 0);
        step(1'b0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
        idle(1);
        check("t5_start_clear", a_cnt, 0);

        // T6: asynchronous reset between edges mid-run.
        do_start();
        idle(10);
        #2;
        sys_rst = 1'b1;
        #1;
        check("t6_async_flags", {a_done, a_pass, a_fail, a_timeout, a_proto, a_tn}, 0);
        check("t6_async_count", a_cnt, 0);
        for (int k = 0; k < 2; k++) model_clear(k);
        @(negedge sys_clk);
        repeat (2) step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        do_start();
        check("t6_restart", a_cnt, 0);
        idle(5);
        check("t6_count", a_cnt, 5);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom % 500) == 0;
            cl = ($urandom % 30) == 0;
            st = ($urandom % 8) == 0;
            case ($urandom % 10)
                0, 1, 2, 3, 4, 5: we = 4'h0;
                6, 7, 8:          we = 4'hF;
                default:          we = 4'($urandom);
            endcase
            case ($urandom % 8)
                0:       ad = 32'h1000;
                1:       ad = 32'h1004;
                2:       ad = 32'h0FFC;
                3:       ad = 32'h1001;
                default: ad = $urandom;
            endcase
            case ($urandom % 4)
                0:       wd = 32'h0;
                1:       wd = 32'h1;
                2:       wd = $urandom | 32'h1;
                default: wd = $urandom & ~32'h1;
            endcase
            step(r, st, cl, we, ad, wd);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
